avalon_gpio_pio: RTL and testbench

//  Parametrised Avalon-MM general-purpose I/O port; successor to the fixed 8-bit output-only PIO.

---
 rtl/avalon_gpio_pio.sv | 70 +++++++
 tb/tb_avalon_gpio_pio.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/avalon_gpio_pio.sv
// avalon_gpio_pio: Avalon-MM GPIO bank with per-bit direction, set/clear, synchronised inputs,
// edge capture and a level interrupt.
module avalon_gpio_pio #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] OUT_RESET   = '0,
    parameter logic [WIDTH-1:0] DIR_RESET   = '0,
    parameter int               SYNC_STAGES = 2,
    parameter int               EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync;
    logic [WIDTH-1:0] in_sync, prev, irqmask, edgecap, edge_hit, wd;
    logic [2:0] arm_cnt;
    logic armed, wr, unused;

    assign wr = chipselect & ~write_n;
    assign wd = writedata[WIDTH-1:0];
    assign unused = ^writedata;
    assign in_sync = sync[SYNC_STAGES-1];
    // edges are ignored until the synchroniser and prev have refilled after reset
    assign armed = arm_cnt == 3'(SYNC_STAGES + 1);
    assign edge_hit = EDGE_TYPE == 0 ? in_sync & ~prev :
                      EDGE_TYPE == 1 ? ~in_sync & prev : in_sync ^ prev;
    assign irq = |(edgecap & irqmask);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync     <= '0;
            prev     <= '0;
            arm_cnt  <= '0;
            out_port <= OUT_RESET;
            oe       <= DIR_RESET;
            irqmask  <= '0;
            edgecap  <= '0;
        end else begin
            sync    <= {sync[SYNC_STAGES-2:0], in_port};
            prev    <= in_sync;
            arm_cnt <= armed ? arm_cnt : arm_cnt + 3'd1;
            if (wr && address == 3'd0) out_port <= wd;
            if (wr && address == 3'd4) out_port <= out_port | wd;
            if (wr && address == 3'd5) out_port <= out_port & ~wd;
            if (wr && address == 3'd1) oe <= wd;
            if (wr && address == 3'd2) irqmask <= wd;
            // a new edge is ORed in after the clear so it is never lost
            edgecap <= (edgecap & ~((wr && address == 3'd3) ? wd : '0)) | (armed ? edge_hit : '0);
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            3'd0: readdata[WIDTH-1:0] = (in_sync & ~oe) | (out_port & oe);
            3'd1: readdata[WIDTH-1:0] = oe;
            3'd2: readdata[WIDTH-1:0] = irqmask;
            3'd3: readdata[WIDTH-1:0] = edgecap;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_avalon_gpio_pio.sv
// tb_avalon_gpio_pio: directed checks of a rising-edge bank and an any-edge bank with
// non-zero reset values, both sharing one bus.
module tb_avalon_gpio_pio;
    logic        clk = 0;
    logic        reset_n = 0;
    logic [2:0]  address = '0;
    logic        chipselect = 0;
    logic        write_n = 1;
    logic [31:0] writedata = '0;
    logic [7:0]  in_port = '0;
    logic [31:0] rd0, rd2, r0, r2;
    logic [7:0]  out0, out2, oe0, oe2;
    logic        irq0, irq2;
    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    avalon_gpio_pio #(.WIDTH(8), .EDGE_TYPE(0)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd0), .in_port(in_port),
        .out_port(out0), .oe(oe0), .irq(irq0)
    );

    avalon_gpio_pio #(.WIDTH(8), .OUT_RESET(8'h3C), .DIR_RESET(8'h0F), .EDGE_TYPE(2)) dut_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd2), .in_port(in_port),
        .out_port(out2), .oe(oe2), .irq(irq2)
    );

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; chipselect = 1; write_n = 0; writedata = d;
        @(negedge clk);
        chipselect = 0; write_n = 1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d0, output logic [31:0] d2);
        address = a;
        #1;
        d0 = rd0;
        d2 = rd2;
    endtask

    task automatic test_reset;
        reset_n = 0;
        in_port = '0;
        repeat (3) @(negedge clk);
        tests_run++; if (out0 !== 8'h00) begin tests_failed++; $display("FAIL reset_out_port: got %h expected %h", out0, 8'h00); end
        tests_run++; if (oe0 !== 8'h00) begin tests_failed++; $display("FAIL reset_oe: got %h expected %h", oe0, 8'h00); end
        tests_run++; if (irq0 !== 1'b0) begin tests_failed++; $display("FAIL reset_irq: got %b expected 0", irq0); end
        tests_run++; if (out2 !== 8'h3C || oe2 !== 8'h0F) begin tests_failed++; $display("FAIL reset_params: got out=%h oe=%h expected out=3c oe=0f", out2, oe2); end
        for (int a = 0; a < 6; a++) begin
            bus_read(3'(a), r0, r2);
            tests_run++; if (r0 !== 32'h0) begin tests_failed++; $display("FAIL reset_read_addr%0d: got %h expected %h", a, r0, 32'h0); end
        end
        bus_read(3'd0, r0, r2);
        tests_run++; if (r2 !== 32'h0C) begin tests_failed++; $display("FAIL reset_data_mixed: got %h expected %h", r2, 32'h0C); end
        bus_read(3'd1, r0, r2);
        tests_run++; if (r2 !== 32'h0F) begin tests_failed++; $display("FAIL reset_dir_param: got %h expected %h", r2, 32'h0F); end
        @(negedge clk);
        reset_n = 1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_out_writes;
        bus_write(3'd0, 32'hFFFF_FFA5);
        tests_run++; if (out0 !== 8'hA5) begin tests_failed++; $display("FAIL write_data: got %h expected %h", out0, 8'hA5); end
        bus_write(3'd4, 32'h0F);
        tests_run++; if (out0 !== 8'hAF) begin tests_failed++; $display("FAIL outset: got %h expected %h", out0, 8'hAF); end
        bus_write(3'd5, 32'h81);
        tests_run++; if (out0 !== 8'h2E) begin tests_failed++; $display("FAIL outclr: got %h expected %h", out0, 8'h2E); end
        bus_read(3'd4, r0, r2);
        tests_run++; if (r0 !== 32'h0) begin tests_failed++; $display("FAIL read_outset: got %h expected %h", r0, 32'h0); end
        bus_read(3'd5, r0, r2);
        tests_run++; if (r0 !== 32'h0) begin tests_failed++; $display("FAIL read_outclr: got %h expected %h", r0, 32'h0); end
        bus_read(3'd0, r0, r2);
        tests_run++; if (r0 !== 32'h0) begin tests_failed++; $display("FAIL read_data_inputs: got %h expected %h", r0, 32'h0); end
        bus_write(3'd6, 32'hFF);
        tests_run++; if (out0 !== 8'h2E) begin tests_failed++; $display("FAIL write_addr6_ignored: got %h expected %h", out0, 8'h2E); end
    endtask

    task automatic test_direction;
        bus_write(3'd1, 32'hF0);
        tests_run++; if (oe0 !== 8'hF0) begin tests_failed++; $display("FAIL dir_oe: got %h expected %h", oe0, 8'hF0); end
        bus_read(3'd1, r0, r2);
        tests_run++; if (r0 !== 32'hF0) begin tests_failed++; $display("FAIL dir_read: got %h expected %h", r0, 32'hF0); end
        @(negedge clk);
        in_port = 8'h03;
        address = 3'd0;
        @(posedge clk); #1;
        tests_run++; if (rd0 !== 32'h20) begin tests_failed++; $display("FAIL data_before_sync: got %h expected %h", rd0, 32'h20); end
        @(posedge clk); #1;
        tests_run++; if (rd0 !== 32'h23) begin tests_failed++; $display("FAIL data_mixed: got %h expected %h", rd0, 32'h23); end
        @(posedge clk); #1;
        address = 3'd3;
        #1;
        tests_run++; if (rd0 !== 32'h03) begin tests_failed++; $display("FAIL edgecap_dir_inputs: got %h expected %h", rd0, 32'h03); end
        @(negedge clk);
        in_port = 8'h00;
        repeat (4) @(negedge clk);
        bus_write(3'd3, 32'hFF);
        bus_read(3'd3, r0, r2);
        tests_run++; if (r0 !== 32'h0 || r2 !== 32'h0) begin tests_failed++; $display("FAIL edgecap_clear_all: got %h/%h expected 0/0", r0, r2); end
    endtask

    task automatic test_edge_irq;
        bus_write(3'd2, 32'h01);
        bus_read(3'd2, r0, r2);
        tests_run++; if (r0 !== 32'h01) begin tests_failed++; $display("FAIL irqmask_read: got %h expected %h", r0, 32'h01); end
        @(negedge clk);
        in_port = 8'h01;
        address = 3'd3;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests_run++; if (rd0 !== 32'h0 || irq0 !== 1'b0) begin tests_failed++; $display("FAIL edge_early: got ec=%h irq=%b expected ec=0 irq=0", rd0, irq0); end
        @(posedge clk); #1;
        tests_run++; if (rd0 !== 32'h01 || irq0 !== 1'b1) begin tests_failed++; $display("FAIL edge_capture: got ec=%h irq=%b expected ec=01 irq=1", rd0, irq0); end
        bus_write(3'd3, 32'h00);
        bus_read(3'd3, r0, r2);
        tests_run++; if (r0 !== 32'h01 || irq0 !== 1'b1) begin tests_failed++; $display("FAIL clear_zero: got ec=%h irq=%b expected ec=01 irq=1", r0, irq0); end
        bus_write(3'd3, 32'h01);
        bus_read(3'd3, r0, r2);
        tests_run++; if (r0 !== 32'h0 || irq0 !== 1'b0) begin tests_failed++; $display("FAIL clear_one: got ec=%h irq=%b expected ec=00 irq=0", r0, irq0); end
        @(negedge clk);
        in_port = 8'h03;
        repeat (4) @(negedge clk);
        bus_read(3'd3, r0, r2);
        tests_run++; if (r0 !== 32'h02 || irq0 !== 1'b0) begin tests_failed++; $display("FAIL unmasked_edge: got ec=%h irq=%b expected ec=02 irq=0", r0, irq0); end
        in_port = 8'h00;
        repeat (4) @(negedge clk);
        bus_write(3'd3, 32'h02);
        bus_read(3'd3, r0, r2);
        tests_run++; if (r0 !== 32'h0) begin tests_failed++; $display("FAIL falling_ignored: got %h expected %h", r0, 32'h0); end
    endtask

    task automatic test_set_wins;
        @(negedge clk);
        in_port = 8'h01;
        @(negedge clk);
        @(negedge clk);
        address = 3'd3; chipselect = 1; write_n = 0; writedata = 32'h01;
        @(negedge clk);
        chipselect = 0; write_n = 1;
        #1;
        tests_run++; if (rd0 !== 32'h01 || irq0 !== 1'b1) begin tests_failed++; $display("FAIL set_wins: got ec=%h irq=%b expected ec=01 irq=1", rd0, irq0); end
        bus_write(3'd3, 32'h01);
        bus_read(3'd3, r0, r2);
        tests_run++; if (r0 !== 32'h0 || irq0 !== 1'b0) begin tests_failed++; $display("FAIL clear_after_set: got ec=%h irq=%b expected ec=00 irq=0", r0, irq0); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        reset_n = 0;
        #1;
        tests_run++; if (out0 !== 8'h00 || oe0 !== 8'h00) begin tests_failed++; $display("FAIL async_reset: got out=%h oe=%h expected 00/00", out0, oe0); end
        tests_run++; if (out2 !== 8'h3C || oe2 !== 8'h0F) begin tests_failed++; $display("FAIL async_reset_params: got out=%h oe=%h expected 3c/0f", out2, oe2); end
        bus_read(3'd2, r0, r2);
        tests_run++; if (r0 !== 32'h0) begin tests_failed++; $display("FAIL async_reset_mask: got %h expected %h", r0, 32'h0); end
    endtask

    task automatic test_armed;
        in_port = 8'hFF;
        repeat (3) @(negedge clk);
        reset_n = 1;
        repeat (8) @(negedge clk);
        bus_read(3'd3, r0, r2);
        tests_run++; if (r0 !== 32'h0 || r2 !== 32'h0) begin tests_failed++; $display("FAIL held_high_no_edge: got %h/%h expected 0/0", r0, r2); end
        in_port = 8'h00;
        repeat (4) @(negedge clk);
        bus_read(3'd3, r0, r2);
        tests_run++; if (r2 !== 32'hFF) begin tests_failed++; $display("FAIL any_edge_fall: got %h expected %h", r2, 32'hFF); end
        tests_run++; if (r0 !== 32'h0) begin tests_failed++; $display("FAIL rising_ignores_fall: got %h expected %h", r0, 32'h0); end
        tests_run++; if (irq2 !== 1'b0) begin tests_failed++; $display("FAIL masked_irq: got %b expected 0", irq2); end
    endtask

    initial begin
        test_reset();
        test_out_writes();
        test_direction();
        test_edge_irq();
        test_set_wins();
        test_reset_mid();
        test_armed();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
